dqsw_wl_tap_ctrl: RTL and testbench
===================================

# dqsw_wl_tap_ctrl

Per-lane DDR3 write-leveling (DQSW) tap controller for the PHY lane 2 DQSW training IOD. It drives that IOD's dynamic delay-line controls and strobe data, and consumes the captured DQ feedback. It sweeps the DQS write delay upward one tap at a time until the DRAM feedback shows a stable 0→1 transition, then reports the tap index to the training sequencer.

## Interface
- MAX_TAPS, 128: delay-line tap limit; tap counter width is 8 bits.
- SETTLE_CYCLES, 8: FAB_CLK cycles between a strobe and its capture.
- SAMPLES, 4: strobes per tap used for the majority vote (1..15).
- STEP_WAIT, 4: FAB_CLK cycles after a delay MOVE before the next strobe.

- FAB_CLK  in  1  single clock; all logic rising-edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle request to begin a sweep.
- BUSY  out  1  high from START acceptance until DONE or ERROR.
- DONE  out  1  level; high after a successful sweep until the next accepted START.
- ERROR  out  1  level; high after a failed sweep until the next accepted START.
- TAP_VALUE  out  8  tap index of the detected transition; valid while DONE.
- DELAY_LINE_LOAD  out  1  one-cycle pulse that restores the delay line to its static base.
- DELAY_LINE_MOVE  out  1  one-cycle pulse that steps the delay line one tap.
- DELAY_LINE_DIRECTION  out  1  held 1 (increment) whenever BUSY, otherwise 0.
- DELAY_LINE_OUT_OF_RANGE  in  1  IOD flag; delay line at its limit.
- EYE_MONITOR_CLEAR_FLAGS  out  1  one-cycle pulse, coincident with DELAY_LINE_LOAD.
- TX_DATA  out  2  strobe data to the IOD: 2'b10 during STROBE, else 2'b00.
- OE_DATA  out  2  strobe output enable: 2'b11 during STROBE, else 2'b00.
- RX_DATA  in  2  captured DQ feedback; a sample counts as 1 only if both bits are 1.

## Operation
- States: IDLE, LOAD, STROBE, SETTLE, CAPTURE, DECIDE, STEP, STEP_WT, DONE_S, ERR_S.
- IDLE/DONE_S/ERR_S + START → LOAD. On acceptance, clear DONE, ERROR, tap counter, sample counters and the seen_zero flag. START is ignored in all other states.
- LOAD: pulse DELAY_LINE_LOAD and EYE_MONITOR_CLEAR_FLAGS → STROBE.
- STROBE (1 cycle): drive the strobe pattern → SETTLE.
- SETTLE: wait SETTLE_CYCLES → CAPTURE.
- CAPTURE (1 cycle): sample RX_DATA. Increment ones_cnt if the sample is 1, and increment samp_cnt. If samp_cnt < SAMPLES, go to STROBE; otherwise go to DECIDE.
- DECIDE: result = (2·ones_cnt > SAMPLES); ties count as 0.
  - result 0: set seen_zero.
  - result 1 and seen_zero: TAP_VALUE ← tap counter → DONE_S.
  - result 1 and !seen_zero: keep sweeping. The initial high region is skipped.
  - If no edge is found and tap counter = MAX_TAPS-1 → ERR_S; otherwise → STEP.
- STEP: if DELAY_LINE_OUT_OF_RANGE = 1 → ERR_S with no MOVE. Otherwise pulse DELAY_LINE_MOVE, increment the tap counter, clear ones_cnt and samp_cnt → STEP_WT.
- STEP_WT: wait STEP_WAIT → STROBE.
- DONE_S/ERR_S: hold outputs and wait for START.
- An edge found at tap 0 is impossible, because seen_zero must be set first. The minimum TAP_VALUE is 1.

## Timing
- Reset values: BUSY=0, DONE=0, ERROR=0, TAP_VALUE=0, DELAY_LINE_LOAD=0, DELAY_LINE_MOVE=0, DELAY_LINE_DIRECTION=0, EYE_MONITOR_CLEAR_FLAGS=0, TX_DATA=00, OE_DATA=00. The state is IDLE.
- All outputs are registered.
- START in cycle n → BUSY=1 and DELAY_LINE_LOAD=1 in cycle n+1.
- Per-tap duration: SAMPLES·(SETTLE_CYCLES+2) + 2 + STEP_WAIT cycles. With the defaults this is 46.
- DONE/ERROR and TAP_VALUE update in the same cycle that BUSY falls, one cycle after DECIDE or STEP.
- DELAY_LINE_OUT_OF_RANGE is checked only in STEP and is ignored in other states.
- RESET asserted mid-sweep: all outputs return to reset values immediately (asynchronous), and no further MOVE is issued. The delay line is re-based by the next sweep's LOAD.
- START coincident with the cycle DONE/ERROR is set is ignored; START is accepted from the following cycle.

## Test plan
- DRAM model returns 0 for taps 0..19 and 1 from tap 20 → DONE=1, ERROR=0, TAP_VALUE=20, exactly 20 MOVE pulses, 1 LOAD pulse.
- Feedback 1 for taps 0..5, 0 for taps 6..30, 1 from tap 31 → TAP_VALUE=31; the initial high region is skipped.
- Feedback always 0 → ERROR=1 after the DECIDE at tap 127, 127 MOVE pulses, DONE=0.
- DELAY_LINE_OUT_OF_RANGE forced high at tap 50 with feedback always 0 → ERROR=1 with no MOVE after tap 50; TAP_VALUE unchanged from its prior value.
- Noisy feedback at tap 12 (2 of 4 samples 1), 0 before, solid 1 at tap 13 → tie counts as 0 and TAP_VALUE=13. Also: 3 of 4 ones at tap 12 → TAP_VALUE=12.
- RESET pulse at tap 8 of a sweep → all outputs at reset values; a new START yields a full sweep and a correct TAP_VALUE. START pulsed while BUSY → ignored, with no extra LOAD pulse.

Source files
------------

// File: rtl/dqsw_wl_tap_ctrl.sv
// DDR3 write-leveling tap controller for one DQSW lane: sweeps the DQS delay
// upward until majority-voted DQ feedback shows a 0->1 transition.
module dqsw_wl_tap_ctrl #(
    parameter int MAX_TAPS      = 128,
    parameter int SETTLE_CYCLES = 8,
    parameter int SAMPLES       = 4,
    parameter int STEP_WAIT     = 4
) (
    input  logic       FAB_CLK,
    input  logic       RESET,
    input  logic       START,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERROR,
    output logic [7:0] TAP_VALUE,
    output logic       DELAY_LINE_LOAD,
    output logic       DELAY_LINE_MOVE,
    output logic       DELAY_LINE_DIRECTION,
    input  logic       DELAY_LINE_OUT_OF_RANGE,
    output logic       EYE_MONITOR_CLEAR_FLAGS,
    output logic [1:0] TX_DATA,
    output logic [1:0] OE_DATA,
    input  logic [1:0] RX_DATA
);

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] LOAD    = 4'd1;
    localparam logic [3:0] STROBE  = 4'd2;
    localparam logic [3:0] SETTLE  = 4'd3;
    localparam logic [3:0] CAPTURE = 4'd4;
    localparam logic [3:0] DECIDE  = 4'd5;
    localparam logic [3:0] STEP    = 4'd6;
    localparam logic [3:0] STEP_WT = 4'd7;
    localparam logic [3:0] DONE_S  = 4'd8;
    localparam logic [3:0] ERR_S   = 4'd9;

    logic [3:0] state_q, state_d;
    logic [7:0] tap_q, tap_d;
    logic [7:0] wait_q, wait_d;
    logic [3:0] samp_q, samp_d;
    logic [3:0] ones_q, ones_d;
    logic       seen_zero_q, seen_zero_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic [7:0] tap_value_q, tap_value_d;
    logic       busy_q, busy_d;
    logic       load_q, load_d;
    logic       move_q, move_d;
    logic       strobe_q, strobe_d;

    logic       vote_one;
    logic       last_tap;

    assign vote_one = {1'b0, ones_q} + {1'b0, ones_q} > 5'(SAMPLES);
    assign last_tap = tap_q == 8'(MAX_TAPS - 1);

    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        wait_d      = wait_q;
        samp_d      = samp_q;
        ones_d      = ones_q;
        seen_zero_d = seen_zero_q;
        done_d      = done_q;
        err_d       = err_q;
        tap_value_d = tap_value_q;
        case (state_q)
            IDLE, DONE_S, ERR_S: begin
                if (START) begin
                    state_d     = LOAD;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    tap_d       = '0;
                    samp_d      = '0;
                    ones_d      = '0;
                    seen_zero_d = 1'b0;
                end
            end
            LOAD:   state_d = STROBE;
            STROBE: begin
                state_d = SETTLE;
                wait_d  = '0;
            end
            SETTLE: begin
                if (wait_q == 8'(SETTLE_CYCLES - 1)) state_d = CAPTURE;
                else wait_d = wait_q + 8'd1;
            end
            CAPTURE: begin
                samp_d = samp_q + 4'd1;
                if (&RX_DATA) ones_d = ones_q + 4'd1;
                if ({1'b0, samp_q} + 5'd1 < 5'(SAMPLES)) state_d = STROBE;
                else state_d = DECIDE;
            end
            DECIDE: begin
                // A 1 only counts as the edge once a 0 has been seen; the
                // leading high region is swept past like any other tap.
                if (vote_one && seen_zero_q) begin
                    tap_value_d = tap_q;
                    done_d      = 1'b1;
                    state_d     = DONE_S;
                end else begin
                    if (!vote_one) seen_zero_d = 1'b1;
                    if (last_tap) begin
                        err_d   = 1'b1;
                        state_d = ERR_S;
                    end else begin
                        state_d = STEP;
                    end
                end
            end
            STEP: begin
                if (DELAY_LINE_OUT_OF_RANGE) begin
                    err_d   = 1'b1;
                    state_d = ERR_S;
                end else begin
                    tap_d   = tap_q + 8'd1;
                    samp_d  = '0;
                    ones_d  = '0;
                    wait_d  = '0;
                    state_d = STEP_WT;
                end
            end
            STEP_WT: begin
                if (wait_q == 8'(STEP_WAIT - 1)) state_d = STROBE;
                else wait_d = wait_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with state_q.
    always_comb begin
        busy_d   = !(state_d == IDLE || state_d == DONE_S || state_d == ERR_S);
        load_d   = state_d == LOAD;
        move_d   = state_q == STEP && state_d == STEP_WT;
        strobe_d = state_d == STROBE;
    end

    always_ff @(posedge FAB_CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            tap_q       <= '0;
            wait_q      <= '0;
            samp_q      <= '0;
            ones_q      <= '0;
            seen_zero_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            tap_value_q <= '0;
            busy_q      <= 1'b0;
            load_q      <= 1'b0;
            move_q      <= 1'b0;
            strobe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            wait_q      <= wait_d;
            samp_q      <= samp_d;
            ones_q      <= ones_d;
            seen_zero_q <= seen_zero_d;
            done_q      <= done_d;
            err_q       <= err_d;
            tap_value_q <= tap_value_d;
            busy_q      <= busy_d;
            load_q      <= load_d;
            move_q      <= move_d;
            strobe_q    <= strobe_d;
        end
    end

    assign BUSY                    = busy_q;
    assign DONE                    = done_q;
    assign ERROR                   = err_q;
    assign TAP_VALUE               = tap_value_q;
    assign DELAY_LINE_LOAD         = load_q;
    assign EYE_MONITOR_CLEAR_FLAGS = load_q;
    assign DELAY_LINE_MOVE         = move_q;
    assign DELAY_LINE_DIRECTION    = busy_q;
    assign TX_DATA                 = strobe_q ? 2'b10 : 2'b00;
    assign OE_DATA                 = strobe_q ? 2'b11 : 2'b00;

endmodule

// File: tb/tb_dqsw_wl_tap_ctrl.sv
// Bench for dqsw_wl_tap_ctrl: a delay-line/DRAM model answers strobes with
// per-tap feedback and a sweep-level model predicts the sweep outcome.
module tb_dqsw_wl_tap_ctrl;

    logic       FAB_CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       START = 1'b0;
    logic       BUSY, DONE, ERROR;
    logic [7:0] TAP_VALUE;
    logic       DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION;
    logic       DELAY_LINE_OUT_OF_RANGE = 1'b0;
    logic       EYE_MONITOR_CLEAR_FLAGS;
    logic [1:0] TX_DATA, OE_DATA;
    logic [1:0] RX_DATA = 2'b00;

    dqsw_wl_tap_ctrl dut (
        .FAB_CLK(FAB_CLK), .RESET(RESET), .START(START), .BUSY(BUSY),
        .DONE(DONE), .ERROR(ERROR), .TAP_VALUE(TAP_VALUE),
        .DELAY_LINE_LOAD(DELAY_LINE_LOAD), .DELAY_LINE_MOVE(DELAY_LINE_MOVE),
        .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION),
        .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE),
        .EYE_MONITOR_CLEAR_FLAGS(EYE_MONITOR_CLEAR_FLAGS),
        .TX_DATA(TX_DATA), .OE_DATA(OE_DATA), .RX_DATA(RX_DATA)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    int n_pass = 0;
    int n_total = 0;
    int ones[128];          // ones out of 4 strobes the DRAM returns per tap
    int oor_tap = 1000;     // tap at which the IOD reports out-of-range
    int cur_tap = 0;
    int strobes = 0;
    int move_cnt = 0;
    int load_cnt = 0;
    int cyc = 0;
    int load_cyc = 0;
    int move_cyc[$];
    int exp_tv = 0;
    logic [1:0] noise;

    always @(posedge FAB_CLK) cyc++;

    // Delay line + DRAM model, updated away from the active edge.
    always @(negedge FAB_CLK) begin
        if (DELAY_LINE_LOAD) begin
            cur_tap = 0; strobes = 0; load_cnt++; load_cyc = cyc;
        end
        if (DELAY_LINE_MOVE) begin
            cur_tap++; strobes = 0; move_cnt++; move_cyc.push_back(cyc);
        end
        if (TX_DATA == 2'b10) begin
            noise = 2'($urandom_range(0, 2));
            RX_DATA = (strobes < ones[cur_tap > 127 ? 127 : cur_tap]) ? 2'b11 : noise;
            strobes++;
        end
        DELAY_LINE_OUT_OF_RANGE = cur_tap >= oor_tap;
    end

    task automatic tick();
        @(negedge FAB_CLK); #1;
    endtask

    // Sweep-level expectation from the majority-vote rule applied per tap.
    task automatic predict(output bit e_done, output bit e_err, output int e_tap,
                           output int e_moves);
        bit seen = 0;
        e_done = 0; e_err = 0; e_tap = exp_tv; e_moves = 0;
        for (int t = 0; t < 128; t++) begin
            if (2 * ones[t] <= 4) seen = 1;
            else if (seen) begin
                e_done = 1; e_tap = t; e_moves = t; return;
            end
            if (t == 127 || t >= oor_tap) begin
                e_err = 1; e_moves = t; return;
            end
        end
    endtask

    task automatic pulse_start(input bit check_issue);
        @(negedge FAB_CLK);
        START = 1'b1;
        @(posedge FAB_CLK); #1;
        if (check_issue) begin
            n_total++;
            if (BUSY !== 1'b1 || DELAY_LINE_LOAD !== 1'b1 || EYE_MONITOR_CLEAR_FLAGS !== 1'b1)
                $display("FAIL start_latency: busy=%b load=%b clr=%b, required 1/1/1",
                         BUSY, DELAY_LINE_LOAD, EYE_MONITOR_CLEAR_FLAGS);
            else n_pass++;
        end
        @(negedge FAB_CLK);
        START = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (BUSY === 1'b1 && n < 8000) begin tick(); n++; end
        if (n >= 8000) begin
            n_total++;
            $display("FAIL %s_timeout: BUSY still %b after %0d cycles, required 0", name, BUSY, n);
        end
    endtask

    task automatic run_sweep(input string name, input bit poke_busy);
        bit e_done, e_err;
        int e_tap, e_moves;
        predict(e_done, e_err, e_tap, e_moves);
        move_cnt = 0; load_cnt = 0; move_cyc.delete();
        pulse_start(1);
        if (poke_busy) begin
            repeat (30) tick();
            pulse_start(0);
        end
        wait_idle(name);
        n_total++;
        if (DONE !== e_done || ERROR !== e_err || TAP_VALUE !== 8'(e_tap)) begin
            $display("FAIL %s_result: done=%b err=%b tap=%0d, required done=%b err=%b tap=%0d",
                     name, DONE, ERROR, TAP_VALUE, e_done, e_err, e_tap);
        end else n_pass++;
        n_total++;
        if (move_cnt != e_moves || load_cnt != 1)
            $display("FAIL %s_pulses: moves=%0d loads=%0d, required moves=%0d loads=1",
                     name, move_cnt, load_cnt, e_moves);
        else n_pass++;
        n_total++;
        if (DELAY_LINE_DIRECTION !== 1'b0 || TX_DATA !== 2'b00 || OE_DATA !== 2'b00)
            $display("FAIL %s_idle_outs: dir=%b tx=%b oe=%b, required 0/00/00",
                     name, DELAY_LINE_DIRECTION, TX_DATA, OE_DATA);
        else n_pass++;
        if (e_done) exp_tv = e_tap;
    endtask

    task automatic set_ones(input int lo, input int hi, input int v);
        for (int t = lo; t <= hi; t++) ones[t] = v;
    endtask

    task automatic check_reset_outs(input string name);
        n_total++;
        if (BUSY !== 0 || DONE !== 0 || ERROR !== 0 || TAP_VALUE !== 8'd0 ||
            DELAY_LINE_LOAD !== 0 || DELAY_LINE_MOVE !== 0 || DELAY_LINE_DIRECTION !== 0 ||
            EYE_MONITOR_CLEAR_FLAGS !== 0 || TX_DATA !== 2'b00 || OE_DATA !== 2'b00)
            $display("FAIL %s: busy=%b done=%b err=%b tap=%0d load=%b move=%b dir=%b clr=%b tx=%b oe=%b, required all zero",
                     name, BUSY, DONE, ERROR, TAP_VALUE, DELAY_LINE_LOAD, DELAY_LINE_MOVE,
                     DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS, TX_DATA, OE_DATA);
        else n_pass++;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) tick();
        check_reset_outs("reset_values");
        RESET = 1'b0;
        exp_tv = 0;
        tick();
    endtask

    task automatic test_basic_edge();
        set_ones(0, 19, 0); set_ones(20, 127, 4); oor_tap = 1000;
        run_sweep("edge20", 0);
        n_total++;
        if (move_cyc.size() < 2 || move_cyc[0] - load_cyc != 43 || move_cyc[1] - move_cyc[0] != 46)
            $display("FAIL tap_period: first_move=%0d period=%0d, required 43/46",
                     move_cyc.size() > 0 ? move_cyc[0] - load_cyc : -1,
                     move_cyc.size() > 1 ? move_cyc[1] - move_cyc[0] : -1);
        else n_pass++;
    endtask

    task automatic test_skip_high();
        set_ones(0, 5, 4); set_ones(6, 30, 0); set_ones(31, 127, 4);
        run_sweep("skip_high", 0);
    endtask

    task automatic test_no_edge();
        set_ones(0, 127, 0);
        run_sweep("no_edge", 0);
    endtask

    task automatic test_out_of_range();
        set_ones(0, 127, 0); oor_tap = 50;
        run_sweep("oor50", 0);
        oor_tap = 1000;
    endtask

    task automatic test_noisy();
        set_ones(0, 11, 0); ones[12] = 2; set_ones(13, 127, 4);
        run_sweep("tie12", 0);
        ones[12] = 3;
        run_sweep("maj12", 0);
    endtask

    task automatic test_mid_reset();
        int n = 0;
        set_ones(0, 39, 0); set_ones(40, 127, 4);
        move_cnt = 0;
        pulse_start(0);
        while (move_cnt < 8 && n < 2000) begin tick(); n++; end
        #2 RESET = 1'b1;
        #1 check_reset_outs("async_reset");
        repeat (60) tick();
        n_total++;
        if (move_cnt != 8) $display("FAIL reset_no_move: moves=%0d, required 8", move_cnt);
        else n_pass++;
        RESET = 1'b0;
        exp_tv = 0;
        tick();
        run_sweep("after_reset", 0);
    endtask

    task automatic test_back_to_back();
        set_ones(0, 9, 0); set_ones(10, 127, 4);
        run_sweep("busy_start", 1);
        for (int i = 0; i < 4; i++) begin
            for (int t = 0; t < 128; t++) ones[t] = $urandom_range(0, 4);
            run_sweep("random", 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic_edge();
        test_skip_high();
        test_no_edge();
        test_out_of_range();
        test_noisy();
        test_mid_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
